// File: rtl/imem_pkg.sv
// Shared encodings and default widths for the instruction-memory port arbiter.
// Owner tags identify which requester a response belongs to.
package imem_pkg;

    localparam int ADDR_W_DEF = 9;
    localparam int XLEN_DEF   = 32;

    typedef enum logic {
        OWN_FETCH  = 1'b0,
        OWN_LOADER = 1'b1
    } owner_e;

    typedef enum logic {
        ST_OPEN   = 1'b0,
        ST_LOCKED = 1'b1
    } lock_state_e;

endpackage

// File: rtl/imem_addr_check.sv
// Alignment and range check on a byte address; yields the memory word address.
// The word address is always produced, even when the address is rejected.
module imem_addr_check #(
    parameter int ADDR_W = 9,
    parameter int XLEN   = 32
) (
    input  logic [XLEN-1:0]   addr_i,
    output logic              err_o,
    output logic [ADDR_W-1:0] waddr_o
);

    assign err_o   = (addr_i[1:0] != 2'b00) || (addr_i[XLEN-1:ADDR_W+2] != '0);
    assign waddr_o = addr_i[ADDR_W+1:2];

endmodule

// File: rtl/imem_port_arbiter.sv
// Arbitrates fetch and loader access to one synchronous-read instruction memory.
// Round-robin on ties, loader burst lock, one-cycle response routing, stall counter.
module imem_port_arbiter
    import imem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int XLEN   = XLEN_DEF,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              f_req,
    input  logic [XLEN-1:0]   f_addr,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [XLEN-1:0]   f_rdata,
    output logic              f_err,
    input  logic              l_req,
    input  logic              l_we,
    input  logic [XLEN-1:0]   l_addr,
    input  logic [XLEN-1:0]   l_wdata,
    input  logic              l_lock,
    output logic              l_gnt,
    output logic              l_rvalid,
    output logic [XLEN-1:0]   l_rdata,
    output logic              l_err,
    output logic              m_en,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [XLEN-1:0]   m_wdata,
    input  logic [XLEN-1:0]   m_rdata,
    output logic [CNT_W-1:0]  stall_cnt
);

    lock_state_e      state_q, state_d;
    owner_e           last_q, last_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic             rsp_valid_q, rsp_err_q, rsp_we_q;
    owner_e           rsp_owner_q;

    logic              any_gnt;
    logic              addr_err;
    logic [ADDR_W-1:0] word_addr;
    logic [XLEN-1:0]   gnt_addr;
    logic [XLEN-1:0]   rsp_data;

    // The requester that did not own the port last wins a tie.
    always_comb begin
        f_gnt = 1'b0;
        l_gnt = 1'b0;
        if (state_q == ST_LOCKED) begin
            l_gnt = l_req;
        end else if (f_req && l_req) begin
            if (last_q == OWN_LOADER) f_gnt = 1'b1;
            else                      l_gnt = 1'b1;
        end else begin
            f_gnt = f_req;
            l_gnt = l_req;
        end
    end

    assign any_gnt  = f_gnt | l_gnt;
    assign gnt_addr = l_gnt ? l_addr : f_addr;

    imem_addr_check #(
        .ADDR_W (ADDR_W),
        .XLEN   (XLEN)
    ) u_addr_check (
        .addr_i  (gnt_addr),
        .err_o   (addr_err),
        .waddr_o (word_addr)
    );

    assign m_en    = any_gnt & ~addr_err;
    assign m_we    = l_gnt & l_we;
    assign m_addr  = any_gnt ? word_addr : '0;
    assign m_wdata = l_gnt ? l_wdata : '0;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        stall_d = stall_q;
        if (l_gnt) state_d = l_lock ? ST_LOCKED : ST_OPEN;
        if (f_gnt)      last_d = OWN_FETCH;
        else if (l_gnt) last_d = OWN_LOADER;
        if (f_req && !f_gnt && (stall_q != '1))
            stall_d = stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    // Response tag is captured on grant; a pending response is dropped by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_OPEN;
            last_q      <= OWN_LOADER;
            stall_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_we_q    <= 1'b0;
            rsp_owner_q <= OWN_FETCH;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            stall_q     <= stall_d;
            rsp_valid_q <= any_gnt;
            rsp_err_q   <= addr_err;
            rsp_we_q    <= m_we;
            rsp_owner_q <= l_gnt ? OWN_LOADER : OWN_FETCH;
        end
    end

    assign rsp_data = (rsp_valid_q && !rsp_err_q && !rsp_we_q) ? m_rdata : '0;

    assign f_rvalid = rsp_valid_q && (rsp_owner_q == OWN_FETCH);
    assign l_rvalid = rsp_valid_q && (rsp_owner_q == OWN_LOADER);
    assign f_rdata  = f_rvalid ? rsp_data : '0;
    assign l_rdata  = l_rvalid ? rsp_data : '0;
    assign f_err    = f_rvalid & rsp_err_q;
    assign l_err    = l_rvalid & rsp_err_q;

    assign stall_cnt = stall_q;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Self-checking bench for imem_port_arbiter: directed scenarios plus randomized
// traffic compared against a transaction-level reference model.
module tb_imem_port_arbiter;

    localparam int WORDS = 512;
    localparam int CNT_MAX = 65535;

    logic        clk = 1'b0;
    logic        rst;
    logic        f_req, l_req, l_we, l_lock;
    logic [31:0] f_addr, l_addr, l_wdata;
    logic        f_gnt, f_rvalid, f_err, l_gnt, l_rvalid, l_err;
    logic [31:0] f_rdata, l_rdata;
    logic        m_en, m_we;
    logic [8:0]  m_addr;
    logic [31:0] m_wdata, m_rdata;
    logic [15:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    imem_port_arbiter dut (
        .clk(clk), .rst(rst),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid),
        .f_rdata(f_rdata), .f_err(f_err),
        .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
        .l_lock(l_lock), .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
        .l_err(l_err),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .stall_cnt(stall_cnt)
    );

    // Synchronous-read memory behind the arbiter, with a preload port for the bench.
    logic [31:0] tbmem [WORDS];
    logic        pre_we = 1'b0;
    logic [8:0]  pre_addr = '0;
    logic [31:0] pre_data = '0;

    always @(posedge clk) begin
        if (pre_we) tbmem[pre_addr] <= pre_data;
        else if (m_en) begin
            if (m_we) tbmem[m_addr] <= m_wdata;
            m_rdata <= tbmem[m_addr];
        end
    end

    // Reference model: port ownership history, lock flag, stall count, memory image.
    bit          mdl_last_loader, mdl_locked;
    int          mdl_stall;
    bit          rsp_v, rsp_loader, rsp_err;
    logic [31:0] rsp_data;
    logic [31:0] ref_mem [WORDS];

    bit          e_fgnt, e_lgnt, e_men, e_mwe, e_bad;
    int          e_idx;
    logic [8:0]  e_maddr;
    logic [31:0] e_mwdata;
    logic [31:0] pa;

    task automatic model_reset();
        mdl_last_loader = 1'b1;
        mdl_locked      = 1'b0;
        mdl_stall       = 0;
        rsp_v           = 1'b0;
    endtask

    task automatic drive(input bit fr, input logic [31:0] fa, input bit lr, input bit lw,
                         input logic [31:0] la, input logic [31:0] ld, input bit ll);
        f_req = fr; f_addr = fa; l_req = lr; l_we = lw; l_addr = la; l_wdata = ld; l_lock = ll;
        #1;
        if (mdl_locked) begin
            e_fgnt = 1'b0; e_lgnt = lr;
        end else if (fr && lr) begin
            e_fgnt = mdl_last_loader; e_lgnt = !mdl_last_loader;
        end else begin
            e_fgnt = fr; e_lgnt = lr;
        end
        pa       = e_lgnt ? la : fa;
        e_bad    = (pa % 4 != 0) || (pa >= WORDS * 4);
        e_idx    = int'((pa / 4) % WORDS);
        e_men    = (e_fgnt || e_lgnt) && !e_bad;
        e_mwe    = e_lgnt && lw;
        e_maddr  = (e_fgnt || e_lgnt) ? e_idx[8:0] : 9'd0;
        e_mwdata = e_lgnt ? ld : 32'd0;
    endtask

    task automatic advance();
        @(posedge clk);
        rsp_v = e_fgnt || e_lgnt;
        if (rsp_v) begin
            rsp_loader = e_lgnt;
            rsp_err    = e_bad;
            rsp_data   = (e_bad || e_mwe) ? 32'd0 : ref_mem[e_idx];
        end
        if (e_mwe && !e_bad) ref_mem[e_idx] = l_wdata;
        if (e_lgnt) mdl_locked = l_lock;
        if (e_fgnt) mdl_last_loader = 1'b0;
        else if (e_lgnt) mdl_last_loader = 1'b1;
        if (f_req && !e_fgnt && mdl_stall < CNT_MAX) mdl_stall++;
        @(negedge clk);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b0;
        #12;
        @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask

    task automatic preload();
        logic [31:0] w;
        rst = 1'b0;
        idle();
        for (int i = 0; i < WORDS; i++) begin
            case (i)
                0: w = 32'h0062E233;
                1: w = 32'h00B62423;
                2: w = 32'hFFC4A303;
                default: w = $urandom;
            endcase
            ref_mem[i] = w;
            pre_we = 1'b1; pre_addr = i[8:0]; pre_data = w;
            @(negedge clk);
        end
        pre_we = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({f_gnt, l_gnt, f_rvalid, l_rvalid, f_err, l_err, m_en, m_we} !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_ctrl got %b want 00000000",
                     {f_gnt, l_gnt, f_rvalid, l_rvalid, f_err, l_err, m_en, m_we});
        end
        checks++;
        if ({f_rdata, l_rdata, m_wdata, m_addr} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_data got %h %h %h %h want 0", f_rdata, l_rdata, m_wdata, m_addr);
        end
        checks++;
        if (stall_cnt !== 16'd0) begin
            errors++;
            $display("[TB] FAIL reset_stall got %0d want 0", stall_cnt);
        end
    endtask

    task automatic test_fetch_alone();
        logic [31:0] words [3];
        words[0] = 32'h0062E233; words[1] = 32'h00B62423; words[2] = 32'hFFC4A303;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            if (i < 3) drive(1, 32'(i * 4), 0, 0, 0, 0, 0);
            else idle();
            if (i < 3) begin
                checks++;
                if (f_gnt !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL fetch_gnt[%0d] got %b want 1", i, f_gnt);
                end
            end
            if (i > 0) begin
                checks++;
                if (f_rvalid !== 1'b1 || f_rdata !== words[i-1] || f_err !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL fetch_rsp[%0d] got v=%b d=%h e=%b want v=1 d=%h e=0",
                             i, f_rvalid, f_rdata, f_err, words[i-1]);
                end
            end
            advance();
        end
    endtask

    task automatic test_alternate();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 1, 0, 32'h4, 0, 0);
            checks++;
            if ({f_gnt, l_gnt} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
                errors++;
                $display("[TB] FAIL alt_gnt[%0d] got %b%b want %s", i, f_gnt, l_gnt,
                         (i % 2 == 0) ? "10" : "01");
            end
            advance();
        end
        idle();
        checks++;
        if (stall_cnt !== 16'd2) begin
            errors++;
            $display("[TB] FAIL alt_stall got %0d want 2", stall_cnt);
        end
        advance();
    endtask

    task automatic test_lock();
        drive(1, 0, 0, 0, 0, 0, 0);
        advance();
        drive(1, 0, 1, 1, 32'h10, 32'hDEADBEEF, 1);
        checks++;
        if ({f_gnt, l_gnt, m_en, m_we} !== 4'b0111 || m_wdata !== 32'hDEADBEEF || m_addr !== 9'd4) begin
            errors++;
            $display("[TB] FAIL lock_wr got gnt=%b%b en=%b we=%b a=%h d=%h want 0111 a=004 d=deadbeef",
                     f_gnt, l_gnt, m_en, m_we, m_addr, m_wdata);
        end
        advance();
        drive(1, 0, 1, 0, 32'h10, 0, 0);
        checks++;
        if ({f_gnt, l_gnt} !== 2'b01 || l_rvalid !== 1'b1 || l_rdata !== 32'd0) begin
            errors++;
            $display("[TB] FAIL lock_rd got gnt=%b%b lv=%b ld=%h want 01 lv=1 ld=0",
                     f_gnt, l_gnt, l_rvalid, l_rdata);
        end
        advance();
        drive(1, 0, 0, 0, 0, 0, 0);
        checks++;
        if (f_gnt !== 1'b1 || l_rvalid !== 1'b1 || l_rdata !== 32'hDEADBEEF) begin
            errors++;
            $display("[TB] FAIL lock_release got fg=%b lv=%b ld=%h want fg=1 lv=1 ld=deadbeef",
                     f_gnt, l_rvalid, l_rdata);
        end
        advance();
    endtask

    task automatic test_bad_addr();
        logic [31:0] bad [2];
        bad[0] = 32'h2; bad[1] = 32'h800;
        for (int i = 0; i < 3; i++) begin
            if (i < 2) drive(1, bad[i], 0, 0, 0, 0, 0);
            else idle();
            if (i < 2) begin
                checks++;
                if (f_gnt !== 1'b1 || m_en !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL bad_drive[%0d] got gnt=%b en=%b want gnt=1 en=0", i, f_gnt, m_en);
                end
            end
            if (i > 0) begin
                checks++;
                if (f_rvalid !== 1'b1 || f_err !== 1'b1 || f_rdata !== 32'd0) begin
                    errors++;
                    $display("[TB] FAIL bad_rsp[%0d] got v=%b e=%b d=%h want v=1 e=1 d=0",
                             i, f_rvalid, f_err, f_rdata);
                end
            end
            advance();
        end
    endtask

    task automatic test_reset_drop();
        drive(1, 32'h4, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        idle();
        checks++;
        if ({f_rvalid, l_rvalid, f_gnt, l_gnt, m_en} !== 5'b0 || f_rdata !== 32'd0 || stall_cnt !== 16'd0) begin
            errors++;
            $display("[TB] FAIL drop_fetch got fv=%b lv=%b d=%h stall=%0d want all 0",
                     f_rvalid, l_rvalid, f_rdata, stall_cnt);
        end
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        drive(0, 0, 1, 0, 32'h8, 0, 1);
        advance();
        rst = 1'b0;
        #2;
        checks++;
        if (l_rvalid !== 1'b0 || l_rdata !== 32'd0) begin
            errors++;
            $display("[TB] FAIL drop_loader got lv=%b ld=%h want 0 0", l_rvalid, l_rdata);
        end
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        drive(1, 0, 1, 0, 0, 0, 0);
        checks++;
        if ({f_gnt, l_gnt} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL drop_unlock got %b%b want 10", f_gnt, l_gnt);
        end
        advance();
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r < 7)       return 32'($urandom_range(0, 31) * 4);
        else if (r == 7) return 32'($urandom_range(0, 31) * 4 + $urandom_range(1, 3));
        else             return 32'h800 + 32'($urandom_range(0, 4095) * 4);
    endfunction

    task automatic test_random();
        bit          ef_v, el_v;
        logic [31:0] ef_d, el_d;
        for (int i = 0; i < 300; i++) begin
            drive($urandom_range(0, 9) < 7, rand_addr(), $urandom_range(0, 1), $urandom_range(0, 1),
                  rand_addr(), $urandom, $urandom_range(0, 3) == 0);
            ef_v = rsp_v && !rsp_loader;
            el_v = rsp_v && rsp_loader;
            ef_d = ef_v ? rsp_data : 32'd0;
            el_d = el_v ? rsp_data : 32'd0;
            checks++;
            if ({f_gnt, l_gnt, m_en, m_we} !== {e_fgnt, e_lgnt, e_men, e_mwe}) begin
                errors++;
                $display("[TB] FAIL rnd_ctrl[%0d] got %b%b%b%b want %b%b%b%b", i,
                         f_gnt, l_gnt, m_en, m_we, e_fgnt, e_lgnt, e_men, e_mwe);
            end
            checks++;
            if (m_addr !== e_maddr || m_wdata !== e_mwdata) begin
                errors++;
                $display("[TB] FAIL rnd_mem[%0d] got a=%h d=%h want a=%h d=%h", i,
                         m_addr, m_wdata, e_maddr, e_mwdata);
            end
            checks++;
            if ({f_rvalid, f_err, l_rvalid, l_err} !== {ef_v, ef_v && rsp_err, el_v, el_v && rsp_err}) begin
                errors++;
                $display("[TB] FAIL rnd_rsp[%0d] got %b%b%b%b want %b%b%b%b", i,
                         f_rvalid, f_err, l_rvalid, l_err, ef_v, ef_v && rsp_err, el_v, el_v && rsp_err);
            end
            checks++;
            if (f_rdata !== ef_d || l_rdata !== el_d) begin
                errors++;
                $display("[TB] FAIL rnd_rdata[%0d] got f=%h l=%h want f=%h l=%h", i,
                         f_rdata, l_rdata, ef_d, el_d);
            end
            checks++;
            if (stall_cnt !== 16'(mdl_stall)) begin
                errors++;
                $display("[TB] FAIL rnd_stall[%0d] got %0d want %0d", i, stall_cnt, mdl_stall);
            end
            advance();
        end
    endtask

    task automatic test_saturate();
        do_reset();
        drive(0, 0, 1, 0, 0, 0, 1);
        advance();
        for (int i = 0; i < CNT_MAX + 7; i++) begin
            drive(1, 0, 0, 0, 0, 0, 0);
            if (i == 1000 || i == CNT_MAX) begin
                checks++;
                if (stall_cnt !== 16'(i)) begin
                    errors++;
                    $display("[TB] FAIL sat_count[%0d] got %0d want %0d", i, stall_cnt, i);
                end
            end
            if (i == 0 || i == CNT_MAX + 6) begin
                checks++;
                if (f_gnt !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL sat_gnt[%0d] got %b want 0", i, f_gnt);
                end
            end
            advance();
        end
        idle();
        checks++;
        if (stall_cnt !== 16'hFFFF) begin
            errors++;
            $display("[TB] FAIL sat_final got %h want ffff", stall_cnt);
        end
    endtask

    initial begin
        rst = 1'b0;
        model_reset();
        preload();
        test_reset();
        test_fetch_alone();
        test_alternate();
        test_lock();
        test_bad_addr();
        test_reset_drop();
        test_random();
        test_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
